mc_control_fsm: RTL and testbench

Multicycle control sequencer for the Filter-GPU ARM-style core. It steps each instruction through fetch, decode, execute, memory and writeback states. In each state it drives the shared datapath's mux selects and write enables, and it stalls on a ready/request handshake with the unified instruction/data memory. It sits in the Control-Unit beside the combinational instruction decoder and takes Op/Funct/Rd/NoWrite from it and CondEx from the condition unit.

---
 rtl/mc_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle fetch/decode/execute/memory/writeback sequencer with memory-wait timeout.
// Define MC_PERF_COUNT_EN to add the cycle_count/instr_count performance counters.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       NoWrite,
    input  logic       CondEx,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemW,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegW,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic [1:0] ResultSrc,
    output logic [3:0] state,
    output logic       instr_retire,
    output logic       illegal,
    output logic       mem_err
`ifdef MC_PERF_COUNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    state_t        cur, nxt;
    logic [CW-1:0] wcnt;
    logic          expired;
    logic          unused;

    assign unused  = ^Funct[4:1];
    assign state   = cur;
    assign expired = !mem_ready && wcnt == CW'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur  <= FETCH;
            wcnt <= '0;
        end else begin
            cur  <= nxt;
            // only the three wait states ever hold, and an abort re-enters FETCH
            wcnt <= (nxt != cur || mem_err) ? '0 : wcnt + 1'b1;
        end
    end

    always_comb begin
        nxt          = cur;
        mem_req      = 1'b0;
        MemW         = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegW         = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 1'b0;
        ResultSrc    = 2'b00;
        instr_retire = 1'b0;
        illegal      = 1'b0;
        mem_err      = 1'b0;
        case (cur)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                mem_err   = expired;
                nxt       = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                illegal   = CondEx && Op == 2'b11;
                nxt       = !CondEx       ? FETCH :
                            Op == 2'b01   ? MEMADR :
                            Op == 2'b10   ? BRANCH :
                            Op == 2'b11   ? FETCH :
                            Funct[5]      ? EXECI : EXECR;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                nxt     = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                mem_err = expired;
                nxt     = mem_ready ? MEMWB : expired ? FETCH : MEMRD;
            end
            MEMWB: begin
                ResultSrc    = 2'b01;
                RegW         = 1'b1;
                PCWrite      = &Rd;
                instr_retire = 1'b1;
                nxt          = FETCH;
            end
            MEMWR: begin
                mem_req      = 1'b1;
                AdrSrc       = 1'b1;
                MemW         = !expired;
                mem_err      = expired;
                instr_retire = mem_ready;
                nxt          = (mem_ready || expired) ? FETCH : MEMWR;
            end
            EXECR: begin
                ALUOp = 1'b1;
                nxt   = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegW         = !NoWrite;
                PCWrite      = &Rd && !NoWrite;
                instr_retire = 1'b1;
                nxt          = FETCH;
            end
            BRANCH: begin
                ALUSrcB      = 2'b01;
                ResultSrc    = 2'b10;
                PCWrite      = 1'b1;
                instr_retire = 1'b1;
                nxt          = FETCH;
            end
            default: nxt = FETCH;
        endcase
        if (expired && cur == FETCH)
            nxt = FETCH;
        // hold every control quiet while reset is asserted
        if (rst) begin
            {mem_req, MemW, AdrSrc, IRWrite, PCWrite, RegW} = '0;
            {ALUSrcA, ALUSrcB, ALUOp, ResultSrc}            = '0;
            {instr_retire, illegal, mem_err}                = '0;
        end
    end

`ifdef MC_PERF_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            instr_count <= instr_count + 32'(instr_retire);
        end
    end
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven check of the control sequencer plus hand sequences for aborts and counters.
module tb_mc_control_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic [3:0] Rd = '0;
    logic       NoWrite = 1'b0;
    logic       CondEx = 1'b1;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemW, AdrSrc, IRWrite, PCWrite, RegW, ALUOp;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state;
    logic       instr_retire, illegal, mem_err;
`ifdef MC_PERF_COUNT_EN
    logic [31:0] cycle_count, instr_count;
`endif

    mc_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd), .NoWrite(NoWrite),
        .CondEx(CondEx), .mem_ready(mem_ready), .mem_req(mem_req), .MemW(MemW),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegW(RegW),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
        .state(state), .instr_retire(instr_retire), .illegal(illegal), .mem_err(mem_err)
`ifdef MC_PERF_COUNT_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    // {mem_req,MemW,AdrSrc,IRWrite,PCWrite,RegW,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,retire,illegal,mem_err}
    logic [15:0] outs;
    assign outs = {mem_req, MemW, AdrSrc, IRWrite, PCWrite, RegW, ALUSrcA, ALUSrcB,
                   ALUOp, ResultSrc, instr_retire, illegal, mem_err};

    localparam logic [15:0] Z       = 16'b0_0_0_0_0_0_00_00_0_00_0_0_0;
    localparam logic [15:0] F_W     = 16'b1_0_0_0_0_0_01_10_0_10_0_0_0;
    localparam logic [15:0] F_R     = 16'b1_0_0_1_1_0_01_10_0_10_0_0_0;
    localparam logic [15:0] F_E     = 16'b1_0_0_0_0_0_01_10_0_10_0_0_1;
    localparam logic [15:0] DEC     = 16'b0_0_0_0_0_0_01_10_0_10_0_0_0;
    localparam logic [15:0] DEC_ILL = 16'b0_0_0_0_0_0_01_10_0_10_0_1_0;
    localparam logic [15:0] MADR    = 16'b0_0_0_0_0_0_00_01_0_00_0_0_0;
    localparam logic [15:0] MRD     = 16'b1_0_1_0_0_0_00_00_0_00_0_0_0;
    localparam logic [15:0] MWB_PC  = 16'b0_0_0_0_1_1_00_00_0_01_1_0_0;
    localparam logic [15:0] MWR_W   = 16'b1_1_1_0_0_0_00_00_0_00_0_0_0;
    localparam logic [15:0] MWR_R   = 16'b1_1_1_0_0_0_00_00_0_00_1_0_0;
    localparam logic [15:0] MWR_E   = 16'b1_0_1_0_0_0_00_00_0_00_0_0_1;
    localparam logic [15:0] EXR     = 16'b0_0_0_0_0_0_00_00_1_00_0_0_0;
    localparam logic [15:0] EXI     = 16'b0_0_0_0_0_0_00_01_1_00_0_0_0;
    localparam logic [15:0] AWB_W   = 16'b0_0_0_0_0_1_00_00_0_00_1_0_0;
    localparam logic [15:0] AWB_N   = 16'b0_0_0_0_0_0_00_00_0_00_1_0_0;
    localparam logic [15:0] BR      = 16'b0_0_0_0_1_0_00_01_0_10_1_0_0;

    typedef struct {
        logic        r;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [3:0]  rd;
        logic        nw;
        logic        ce;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] o;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic void add(logic r, logic [1:0] op, logic [5:0] fn, logic [3:0] rd,
                                logic nw, logic ce, logic rdy, logic [3:0] st, logic [15:0] o);
        vecs.push_back('{r, op, fn, rd, nw, ce, rdy, st, o});
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    initial begin
        int err_n, ret_n, regw_n, irw_n;
        add(1, 2'd0, 6'b001000, 4'd3,  0, 1, 1, 4'd0, Z);
        // ADD register form
        add(0, 2'd0, 6'b001000, 4'd3,  0, 1, 1, 4'd0, F_R);
        add(0, 2'd0, 6'b001000, 4'd3,  0, 1, 1, 4'd1, DEC);
        add(0, 2'd0, 6'b001000, 4'd3,  0, 1, 1, 4'd6, EXR);
        add(0, 2'd0, 6'b001000, 4'd3,  0, 1, 1, 4'd8, AWB_W);
        // LDR to PC, three wait cycles in MEMRD
        add(0, 2'd1, 6'b000001, 4'd15, 0, 1, 1, 4'd0, F_R);
        add(0, 2'd1, 6'b000001, 4'd15, 0, 1, 1, 4'd1, DEC);
        add(0, 2'd1, 6'b000001, 4'd15, 0, 1, 0, 4'd2, MADR);
        add(0, 2'd1, 6'b000001, 4'd15, 0, 1, 0, 4'd3, MRD);
        add(0, 2'd1, 6'b000001, 4'd15, 0, 1, 0, 4'd3, MRD);
        add(0, 2'd1, 6'b000001, 4'd15, 0, 1, 0, 4'd3, MRD);
        add(0, 2'd1, 6'b000001, 4'd15, 0, 1, 1, 4'd3, MRD);
        add(0, 2'd1, 6'b000001, 4'd15, 0, 1, 0, 4'd4, MWB_PC);
        // STR
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 1, 4'd0, F_R);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 0, 4'd1, DEC);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 1, 4'd2, MADR);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 1, 4'd5, MWR_R);
        // CMP immediate with Rd=15
        add(0, 2'd0, 6'b110101, 4'd15, 1, 1, 1, 4'd0, F_R);
        add(0, 2'd0, 6'b110101, 4'd15, 1, 1, 1, 4'd1, DEC);
        add(0, 2'd0, 6'b110101, 4'd15, 1, 1, 1, 4'd7, EXI);
        add(0, 2'd0, 6'b110101, 4'd15, 1, 1, 1, 4'd8, AWB_N);
        // condition fail, then illegal, then branch
        add(0, 2'd0, 6'b001000, 4'd3,  0, 0, 1, 4'd0, F_R);
        add(0, 2'd0, 6'b001000, 4'd3,  0, 0, 1, 4'd1, DEC);
        add(0, 2'd3, 6'b000000, 4'd0,  0, 1, 1, 4'd0, F_R);
        add(0, 2'd3, 6'b000000, 4'd0,  0, 1, 1, 4'd1, DEC_ILL);
        add(0, 2'd2, 6'b000000, 4'd0,  0, 1, 1, 4'd0, F_R);
        add(0, 2'd2, 6'b000000, 4'd0,  0, 1, 1, 4'd1, DEC);
        add(0, 2'd2, 6'b000000, 4'd0,  0, 1, 1, 4'd9, BR);
        // ADD immediate with one fetch wait
        add(0, 2'd0, 6'b100000, 4'd3,  0, 1, 0, 4'd0, F_W);
        add(0, 2'd0, 6'b100000, 4'd3,  0, 1, 1, 4'd0, F_R);
        add(0, 2'd0, 6'b100000, 4'd3,  0, 1, 1, 4'd1, DEC);
        add(0, 2'd0, 6'b100000, 4'd3,  0, 1, 1, 4'd7, EXI);
        add(0, 2'd0, 6'b100000, 4'd3,  0, 1, 1, 4'd8, AWB_W);
        // fetch timeout twice in a row, counter restarts after abort
        for (int k = 0; k < 2; k++) begin
            add(0, 2'd1, 6'b000000, 4'd2, 0, 1, 0, 4'd0, F_W);
            add(0, 2'd1, 6'b000000, 4'd2, 0, 1, 0, 4'd0, F_W);
            add(0, 2'd1, 6'b000000, 4'd2, 0, 1, 0, 4'd0, F_W);
            add(0, 2'd1, 6'b000000, 4'd2, 0, 1, 0, 4'd0, F_E);
        end
        // store timeout
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 1, 4'd0, F_R);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 1, 4'd1, DEC);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 1, 4'd2, MADR);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 0, 4'd5, MWR_W);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 0, 4'd5, MWR_W);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 0, 4'd5, MWR_W);
        add(0, 2'd1, 6'b000000, 4'd2,  0, 1, 0, 4'd5, MWR_E);
        // reset in MEMRD
        add(0, 2'd1, 6'b000001, 4'd4,  0, 1, 1, 4'd0, F_R);
        add(0, 2'd1, 6'b000001, 4'd4,  0, 1, 1, 4'd1, DEC);
        add(0, 2'd1, 6'b000001, 4'd4,  0, 1, 1, 4'd2, MADR);
        add(0, 2'd1, 6'b000001, 4'd4,  0, 1, 0, 4'd3, MRD);
        add(1, 2'd1, 6'b000001, 4'd4,  0, 1, 1, 4'd0, Z);
        add(0, 2'd1, 6'b000001, 4'd4,  0, 1, 0, 4'd0, F_W);
        add(0, 2'd1, 6'b000001, 4'd4,  0, 1, 1, 4'd0, F_R);
        add(0, 2'd1, 6'b000001, 4'd4,  0, 1, 1, 4'd1, DEC);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r; Op = vecs[i].op; Funct = vecs[i].fn; Rd = vecs[i].rd;
            NoWrite = vecs[i].nw; CondEx = vecs[i].ce; mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d outs", i), 32'(outs), 32'(vecs[i].o));
        end

        // LDR whose memory never answers: 7 cycles per abort, 21 cycles gives 3 aborts
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        Op = 2'd1; Funct = 6'b000001; Rd = 4'd4; NoWrite = 1'b0; CondEx = 1'b1;
        err_n = 0; ret_n = 0; regw_n = 0;
        for (int c = 0; c < 21; c++) begin
            if (c > 0) @(negedge clk);
            mem_ready = (state == 4'd0);
            #1;
            err_n += int'(mem_err); ret_n += int'(instr_retire); regw_n += int'(RegW);
        end
        @(negedge clk); #1;
        chk("ldr_abort mem_err count", 32'(err_n), 32'd3);
        chk("ldr_abort retire count", 32'(ret_n), 32'd0);
        chk("ldr_abort regw count", 32'(regw_n), 32'd0);
        chk("ldr_abort end state", 32'(state), 32'd0);

        // fetch starved with MEM_TIMEOUT=4: mem_err only in 4th cycle, IRWrite never
        mem_ready = 1'b0; err_n = 0; irw_n = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c == 3) chk("fetch_to 4th cycle mem_err", 32'(mem_err), 32'd1);
            err_n += int'(mem_err); irw_n += int'(IRWrite);
        end
        chk("fetch_to mem_err count", 32'(err_n), 32'd1);
        chk("fetch_to irwrite count", 32'(irw_n), 32'd0);

`ifdef MC_PERF_COUNT_EN
        @(negedge clk); rst = 1'b1;
        #1;
        chk("perf reset cycle_count", cycle_count, 32'd0);
        chk("perf reset instr_count", instr_count, 32'd0);
        @(negedge clk); rst = 1'b0;
        Op = 2'd0; Funct = 6'b001000; Rd = 4'd3; NoWrite = 1'b0; CondEx = 1'b1; mem_ready = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("perf cycle_count after 3 ADD", cycle_count, 32'd12);
        chk("perf instr_count after 3 ADD", instr_count, 32'd3);
        chk("perf state after 3 ADD", 32'(state), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
